// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner ids and access lengths.
// The access-length values mirror the `word/`half/`byte encodings of Marco.v.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DARB_IDLE   = 2'd0,
    DARB_ACCESS = 2'd1,
    DARB_RESP   = 2'd2
  } darb_state_e;

  localparam logic DARB_CPU = 1'b0;
  localparam logic DARB_DMA = 1'b1;

  localparam logic [1:0] LEN_WORD = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_BYTE = 2'd2;

  // A word must sit on a 4-byte boundary and a half on a 2-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] memlen, input logic [1:0] addr_lo);
    is_misaligned = ((memlen == LEN_WORD) && (addr_lo != 2'b00)) ||
                    ((memlen == LEN_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin chooser: masked requests in, one winner out.
// On a tie the requester that was not granted last wins.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    grant_valid = |eligible;
    grant_id    = 1'b0;
    case (eligible)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the MEM stage (cpu_*) and a DMA/debug loader (dma_*).
// Optional alignment checking is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int   ADDR_W    = 32,
  parameter int   DATA_W    = 32,
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_memlen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_memlen,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic              dma_stall,
  output logic              mem_we,
  output logic [1:0]        mem_memlen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  darb_state_e state, state_next;

  logic              owner;
  logic              last_grant;
  logic              req_we;
  logic [1:0]        req_memlen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_err;
  logic [DATA_W-1:0] resp_data;

  logic [1:0]        req_vec;
  logic [1:0]        mask;
  logic              grant_valid;
  logic              grant_id;
  logic              grant_en;

  logic              sel_we;
  logic [1:0]        sel_memlen;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  logic              in_access;
  logic              in_resp;

  assign in_access = (state == DARB_ACCESS);
  assign in_resp   = (state == DARB_RESP);

  // The owner being acked still shows its old request, so it sits out this round.
  assign req_vec = {dma_req, cpu_req};
  assign mask    = in_resp ? ((owner == DARB_DMA) ? 2'b10 : 2'b01) : 2'b00;

  dmem_rr_pick u_pick (
    .req         (req_vec),
    .mask        (mask),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant_en = grant_valid && (state == DARB_IDLE || in_resp);

  always_comb begin
    sel_we     = cpu_we;
    sel_memlen = cpu_memlen;
    sel_addr   = cpu_addr;
    sel_wdata  = cpu_wdata;
    if (grant_id == DARB_DMA) begin
      sel_we     = dma_we;
      sel_memlen = dma_memlen;
      sel_addr   = dma_addr;
      sel_wdata  = dma_wdata;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign sel_err = is_misaligned(sel_memlen, sel_addr[1:0]);
`else
  assign sel_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      DARB_IDLE:   if (grant_valid) state_next = DARB_ACCESS;
      DARB_ACCESS: state_next = DARB_RESP;
      DARB_RESP:   state_next = grant_valid ? DARB_ACCESS : DARB_IDLE;
      default:     state_next = DARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DARB_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= DARB_CPU;
      last_grant <= INIT_PRIO;
      req_we     <= 1'b0;
      req_memlen <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_err    <= 1'b0;
    end else if (grant_en) begin
      owner      <= grant_id;
      last_grant <= grant_id;
      req_we     <= sel_we;
      req_memlen <= sel_memlen;
      req_addr   <= sel_addr;
      req_wdata  <= sel_wdata;
      req_err    <= sel_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            resp_data <= '0;
    else if (in_access) resp_data <= mem_rdata;
  end

  // Memory port is quiet outside ACCESS; a flagged access never writes.
  always_comb begin
    mem_we     = 1'b0;
    mem_memlen = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (in_access) begin
      mem_we     = req_we & ~req_err;
      mem_memlen = req_memlen;
      mem_addr   = req_addr;
      mem_wdata  = req_wdata;
    end
  end

  always_comb begin
    cpu_ack   = in_resp && (owner == DARB_CPU);
    dma_ack   = in_resp && (owner == DARB_DMA);
    cpu_rdata = (cpu_ack && !req_err) ? resp_data : '0;
    dma_rdata = (dma_ack && !req_err) ? resp_data : '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    cpu_err   = cpu_ack && req_err;
    dma_err   = dma_ack && req_err;
`else
    cpu_err   = 1'b0;
    dma_err   = 1'b0;
`endif
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign dma_stall = dma_req & ~dma_ack;

  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(cpu_ack && dma_ack));
  a_we_in_access:  assert property (@(posedge clk) disable iff (rst) mem_we |-> in_access);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a byte-level reference memory.
// Expected err/rdata follow DMEM_ARB_ALIGN_CHECK_EN when it is defined.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk, rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
  logic [1:0]  cpu_memlen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack, dma_err, dma_stall;
  logic [1:0]  dma_memlen;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [1:0]  mem_memlen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        r_req[2];
  logic        r_we[2];
  logic [1:0]  r_len[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  int          r_start[2];

  logic [7:0]  tmem[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  ra;

  int          cyc, vectors, miscompares, we_cnt;
  int          stall_cnt[2];
  int          ack_id_q[$];
  int          ack_cyc_q[$];
  logic [31:0] last_rdata[2];
  logic        last_err[2];

  logic [1:0]  ack_v, stall_v, err_v;
  logic [31:0] rdata_v[2];

  assign cpu_req = r_req[0];   assign dma_req = r_req[1];
  assign cpu_we = r_we[0];     assign dma_we = r_we[1];
  assign cpu_memlen = r_len[0]; assign dma_memlen = r_len[1];
  assign cpu_addr = r_addr[0]; assign dma_addr = r_addr[1];
  assign cpu_wdata = r_wdata[0]; assign dma_wdata = r_wdata[1];
  assign ack_v = {dma_ack, cpu_ack};
  assign stall_v = {dma_stall, cpu_stall};
  assign err_v = {dma_err, cpu_err};
  assign rdata_v[0] = cpu_rdata;
  assign rdata_v[1] = dma_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_memlen(cpu_memlen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_memlen(dma_memlen), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .dma_stall(dma_stall),
    .mem_we(mem_we), .mem_memlen(mem_memlen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Environment memory: combinational read, posedge write, zero-extended reads.
  assign ra = mem_addr[7:0];
  always_comb begin
    case (mem_memlen)
      LEN_WORD: mem_rdata = {tmem[ra + 8'd3], tmem[ra + 8'd2], tmem[ra + 8'd1], tmem[ra]};
      LEN_HALF: mem_rdata = {16'h0, tmem[ra + 8'd1], tmem[ra]};
      LEN_BYTE: mem_rdata = {24'h0, tmem[ra]};
      default:  mem_rdata = 32'h0;
    endcase
  end

  initial begin
    cyc = 0;
    for (int i = 0; i < 256; i++) begin
      tmem[i]    = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (mem_we) begin
        tmem[ra] = mem_wdata[7:0];
        if (mem_memlen != LEN_BYTE) tmem[ra + 8'd1] = mem_wdata[15:8];
        if (mem_memlen == LEN_WORD) begin
          tmem[ra + 8'd2] = mem_wdata[23:16];
          tmem[ra + 8'd3] = mem_wdata[31:24];
        end
      end
    end
  end

  function automatic logic exp_err(input logic [1:0] len, input logic [31:0] addr);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return (len == LEN_WORD && addr[1:0] != 2'b00) || (len == LEN_HALF && addr[0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input logic [1:0] len, input logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    if (len == LEN_WORD) return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    if (len == LEN_HALF) return {16'h0, ref_mem[a + 8'd1], ref_mem[a]};
    return {24'h0, ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [1:0] len, input logic [31:0] addr, input logic [31:0] d);
    logic [7:0] a;
    a = addr[7:0];
    ref_mem[a] = d[7:0];
    if (len != LEN_BYTE) ref_mem[a + 8'd1] = d[15:8];
    if (len == LEN_WORD) begin
      ref_mem[a + 8'd2] = d[23:16];
      ref_mem[a + 8'd3] = d[31:24];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic we, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata);
    r_we[id]    = we;
    r_len[id]   = len;
    r_addr[id]  = addr;
    r_wdata[id] = wdata;
    r_req[id]   = 1'b1;
    r_start[id] = cyc;
  endtask

  task automatic dropReq(input int id);
    r_req[id] = 1'b0;
  endtask

  task automatic waitAck(input int id);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ack_v[id]) done = 1'b1;
      else begin
        waited++;
        if (waited > 8) begin
          checkOutput("ack_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic singleAccess(input int id, input logic we, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int b, t;
    @(posedge clk); #1;
    b = ack_cyc_q.size();
    applyStimulus(id, we, len, addr, wdata);
    t = cyc;
    waitAck(id);
    @(posedge clk); #1;
    dropReq(id);
    lat = (ack_cyc_q.size() > b) ? ack_cyc_q[b] - t : -1;
  endtask

  // Random requester: optional idle gaps, new request right after each ack.
  task automatic requester(input int id, input int n, input int idle_pct);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
        dropReq(id);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      applyStimulus(id, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    32'($urandom_range(0, 63)), $urandom);
      waitAck(id);
    end
    @(posedge clk); #1;
    dropReq(id);
  endtask

  task automatic doReset();
    rst = 1'b1;
    dropReq(0);
    dropReq(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle monitor: scoreboard against the reference memory on every ack.
  int    mon_lat;
  logic  mon_err;
  string mon_nm;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we) we_cnt++;
        checkOutput("ack_overlap", 32'(cpu_ack & dma_ack), 32'd0);
        for (int id = 0; id < 2; id++) begin
          mon_nm = (id == 0) ? "cpu" : "dma";
          stall_cnt[id] += int'(stall_v[id]);
          checkOutput({mon_nm, "_stall"}, 32'(stall_v[id]), 32'(r_req[id] & ~ack_v[id]));
          checkOutput({mon_nm, "_spurious_ack"}, 32'(ack_v[id] & ~r_req[id]), 32'd0);
          if (ack_v[id] && r_req[id]) begin
            mon_err = exp_err(r_len[id], r_addr[id]);
            checkOutput({mon_nm, "_err"}, 32'(err_v[id]), 32'(mon_err));
            if (!r_we[id] || mon_err)
              checkOutput({mon_nm, "_rdata"}, rdata_v[id],
                          mon_err ? 32'h0 : ref_read(r_len[id], r_addr[id]));
            if (r_we[id] && !mon_err) ref_write(r_len[id], r_addr[id], r_wdata[id]);
            mon_lat = cyc - r_start[id];
            checkOutput({mon_nm, "_latency_range"}, 32'(mon_lat >= 2 && mon_lat <= 4), 32'd1);
            ack_id_q.push_back(id);
            ack_cyc_q.push_back(cyc);
            last_rdata[id] = rdata_v[id];
            last_err[id]   = err_v[id];
          end
        end
      end
    end
  end

  int b, t0, w0, s0, lat;
  initial begin
    vectors = 0; miscompares = 0; we_cnt = 0;
    stall_cnt[0] = 0; stall_cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_len[i] = 2'd0;
      r_addr[i] = 32'h0; r_wdata[i] = 32'h0; r_start[i] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("rst_dma_ack", 32'(dma_ack), 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_dma_err", 32'(dma_err), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_memlen", 32'(mem_memlen), 32'd0);
    rst = 1'b0;

    $display("[TB] CPU store/load word at 0x10");
    @(posedge clk); #1;
    w0 = we_cnt; s0 = stall_cnt[0]; b = ack_cyc_q.size();
    applyStimulus(0, 1'b1, LEN_WORD, 32'h10, 32'hDEADBEEF);
    t0 = cyc;
    #1 checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    checkOutput("access_mem_we", 32'(mem_we), 32'd1);
    checkOutput("access_mem_addr", mem_addr, 32'h10);
    checkOutput("access_mem_wdata", mem_wdata, 32'hDEADBEEF);
    waitAck(0);
    @(posedge clk); #1;
    dropReq(0);
    checkOutput("store_we_cycles", 32'(we_cnt - w0), 32'd1);
    checkOutput("store_stall_cycles", 32'(stall_cnt[0] - s0), 32'd2);
    checkOutput("store_ack_count", 32'(ack_cyc_q.size() - b), 32'd1);
    if (ack_cyc_q.size() > b) checkOutput("store_latency", 32'(ack_cyc_q[b] - t0), 32'd2);
    s0 = stall_cnt[0];
    singleAccess(0, 1'b0, LEN_WORD, 32'h10, 32'h0, lat);
    checkOutput("load_latency", 32'(lat), 32'd2);
    checkOutput("load_rdata", last_rdata[0], 32'hDEADBEEF);
    checkOutput("load_stall_cycles", 32'(stall_cnt[0] - s0), 32'd2);

    $display("[TB] simultaneous first requests after reset");
    doReset();
    b = ack_cyc_q.size();
    fork
      requester(0, 1, 0);
      requester(1, 1, 0);
    join
    checkOutput("tie_ack_count", 32'(ack_cyc_q.size() - b), 32'd2);
    if (ack_cyc_q.size() >= b + 2) begin
      checkOutput("tie_first_is_dma", 32'(ack_id_q[b]), 32'd1);
      checkOutput("tie_second_is_cpu", 32'(ack_id_q[b + 1]), 32'd0);
      checkOutput("tie_first_latency", 32'(ack_cyc_q[b] - r_start[1]), 32'd2);
      checkOutput("tie_ack_spacing", 32'(ack_cyc_q[b + 1] - ack_cyc_q[b]), 32'd2);
    end

    $display("[TB] both requesters held for 8 accesses");
    b = ack_cyc_q.size();
    fork
      requester(0, 4, 0);
      requester(1, 4, 0);
    join
    checkOutput("rr_ack_count", 32'(ack_cyc_q.size() - b), 32'd8);
    for (int i = b + 1; i < ack_cyc_q.size(); i++) begin
      checkOutput("rr_alternate", 32'(ack_id_q[i] != ack_id_q[i - 1]), 32'd1);
      checkOutput("rr_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i - 1]), 32'd2);
    end

    $display("[TB] reset during a DMA store to 0x20");
    @(posedge clk); #1;
    b = ack_cyc_q.size(); w0 = we_cnt;
    applyStimulus(1, 1'b1, LEN_WORD, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    checkOutput("abort_mem_we_before", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    dropReq(1);
    #1;
    checkOutput("abort_mem_we_after", 32'(mem_we), 32'd0);
    checkOutput("abort_dma_ack", 32'(dma_ack), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_no_ack", 32'(ack_cyc_q.size() - b), 32'd0);
    singleAccess(0, 1'b0, LEN_WORD, 32'h20, 32'h0, lat);
    checkOutput("abort_idle_latency", 32'(lat), 32'd2);
    checkOutput("abort_0x20_unchanged", last_rdata[0], ref_read(LEN_WORD, 32'h20));

    $display("[TB] misaligned word store to 0x22");
    w0 = we_cnt;
    singleAccess(0, 1'b1, LEN_WORD, 32'h22, 32'hCAFEF00D, lat);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    checkOutput("misalign_we_cycles", 32'(we_cnt - w0), 32'd0);
    checkOutput("misalign_err", 32'(last_err[0]), 32'd1);
    checkOutput("misalign_rdata", last_rdata[0], 32'd0);
`else
    checkOutput("misalign_we_cycles", 32'(we_cnt - w0), 32'd1);
    checkOutput("misalign_err", 32'(last_err[0]), 32'd0);
`endif
    checkOutput("misalign_latency", 32'(lat), 32'd2);
    singleAccess(0, 1'b0, LEN_WORD, 32'h22, 32'h0, lat);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    checkOutput("misalign_load", last_rdata[0], 32'd0);
`else
    checkOutput("misalign_load", last_rdata[0], 32'hCAFEF00D);
`endif

    $display("[TB] random traffic");
    fork
      requester(0, 40, 40);
      requester(1, 40, 40);
    join
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
